// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//
// Program-counter unit for the fetch stage. It holds the PC register and
// works out the sequential (PC + INC) and branch-target
// (base + offset << SHIFT) sums. Each cycle it picks the next PC from reset,
// jump, branch, a buffered (pending) redirect, or the sequential address.
//
// A redirect that arrives while the pipeline is stalled is buffered rather
// than dropped. It is loaded on the first non-stalled cycle, unless a
// younger redirect arrives in that same cycle.
//
// Parameters
//   WIDTH     width of every address bus
//   INC       sequential increment
//   SHIFT     offset shift and address alignment (low SHIFT bits are zero)
//   RESET_PC  PC value loaded while Reset is high
//
// Ports
//   Clk              in   1      clock, all state changes on the rising edge
//   Reset            in   1      synchronous, active-high
//   Stall            in   1      hold the PC this cycle
//   BranchTaken      in   1      redirect to BranchTarget
//   BranchBase       in   WIDTH  base of the branch sum
//   BranchOffset     in   WIDTH  sign-extended word offset
//   JumpEn           in   1      redirect to JumpTarget (beats BranchTaken)
//   JumpTarget       in   WIDTH  absolute jump address
//   PCResult         out  WIDTH  current PC (registered)
//   PCAddResult      out  WIDTH  PCResult + INC (combinational)
//   BranchTarget     out  WIDTH  BranchBase + (BranchOffset << SHIFT) (comb.)
//   PCValid          out  1      PCResult is a fetchable address (registered)
//   RedirectPending  out  1      a redirect is buffered behind a stall (reg.)
//   MisalignErr      out  1      one-cycle pulse: a loaded target had nonzero
//                                low SHIFT bits (registered)
// ---------------------------------------------------------------------------
module pc_sequencer #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned INC      = 4,
    parameter int unsigned SHIFT    = 2,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Stall,
    input  logic             BranchTaken,
    input  logic [WIDTH-1:0] BranchBase,
    input  logic [WIDTH-1:0] BranchOffset,
    input  logic             JumpEn,
    input  logic [WIDTH-1:0] JumpTarget,
    output logic [WIDTH-1:0] PCResult,
    output logic [WIDTH-1:0] PCAddResult,
    output logic [WIDTH-1:0] BranchTarget,
    output logic             PCValid,
    output logic             RedirectPending,
    output logic             MisalignErr
);

    // Increment at bus width, so the sum wraps modulo 2^WIDTH.
    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    // Mask of the alignment bits. It is built through a wide intermediate
    // so that SHIFT = 0 gives an all-zero mask instead of an illegal slice.
    localparam logic [63:0]      LOW_MASK_64 = (64'd1 << SHIFT) - 64'd1;
    localparam logic [WIDTH-1:0] LOW_MASK    = LOW_MASK_64[WIDTH-1:0];

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pending_target;
    logic             pending;
    logic             valid;
    logic             misalign;

    logic             redirect;
    logic [WIDTH-1:0] redirect_target;
    logic [WIDTH-1:0] shifted_offset;

    // Sequential and branch sums. The shift runs at bus width, so the top
    // SHIFT bits of the offset fall off, and both sums wrap without carry-out.
    always_comb begin
        shifted_offset = BranchOffset << SHIFT;
        PCAddResult    = pc + INC_W;
        BranchTarget   = BranchBase + shifted_offset;
    end

    // Same-cycle redirect select: a jump beats a branch.
    always_comb begin
        redirect        = JumpEn | BranchTaken;
        redirect_target = JumpEn ? JumpTarget : BranchTarget;
    end

    // PC, pending-redirect buffer and status flags.
    // Targets are aligned and checked only when they load into the PC, never
    // when they are buffered. A new redirect on the release cycle is younger
    // than the buffered one, so it wins and the buffer is discarded.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc             <= RESET_PC;
            valid          <= 1'b0;
            pending        <= 1'b0;
            pending_target <= '0;
            misalign       <= 1'b0;
        end else begin
            valid    <= 1'b1;
            misalign <= 1'b0;
            if (Stall) begin
                if (redirect) begin
                    pending        <= 1'b1;
                    pending_target <= redirect_target;
                end
            end else if (redirect) begin
                pc       <= redirect_target & ~LOW_MASK;
                pending  <= 1'b0;
                misalign <= |(redirect_target & LOW_MASK);
            end else if (pending) begin
                pc       <= pending_target & ~LOW_MASK;
                pending  <= 1'b0;
                misalign <= |(pending_target & LOW_MASK);
            end else begin
                pc <= PCAddResult;
            end
        end
    end

    assign PCResult        = pc;
    assign PCValid         = valid;
    assign RedirectPending = pending;
    assign MisalignErr     = misalign;

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//
// Directed bench for pc_sequencer with the default parameters
// (WIDTH 32, INC 4, SHIFT 2, RESET_PC 0).
//
// Inputs are driven 1 time unit after each rising edge. Outputs are sampled
// at that same point, once the registered outputs have settled. Expected
// values are worked out by hand from the PC rules.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_base;
    logic [31:0] branch_offset;
    logic        jump_en;
    logic [31:0] jump_target;
    logic [31:0] pc_result;
    logic [31:0] pc_add_result;
    logic [31:0] branch_target;
    logic        pc_valid;
    logic        redirect_pending;
    logic        misalign_err;

    int compared   = 0;
    int mismatched = 0;

    pc_sequencer dut (
        .Clk             (clk),
        .Reset           (reset),
        .Stall           (stall),
        .BranchTaken     (branch_taken),
        .BranchBase      (branch_base),
        .BranchOffset    (branch_offset),
        .JumpEn          (jump_en),
        .JumpTarget      (jump_target),
        .PCResult        (pc_result),
        .PCAddResult     (pc_add_result),
        .BranchTarget    (branch_target),
        .PCValid         (pc_valid),
        .RedirectPending (redirect_pending),
        .MisalignErr     (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h",
                   tag, observed, expected);
        end
    endtask

    // Return every redirect/stall input to idle.
    task automatic idle_inputs();
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_base   = 32'h0;
        branch_offset = 32'h0;
        jump_en       = 1'b0;
        jump_target   = 32'h0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();

        // Reset for two edges.
        step();
        step();
        check_output("reset_pc",      pc_result,        32'h0);
        check_output("reset_valid",   {31'b0, pc_valid},         32'h0);
        check_output("reset_pending", {31'b0, redirect_pending}, 32'h0);
        check_output("reset_misalign",{31'b0, misalign_err},     32'h0);
        check_output("reset_add",     pc_add_result,    32'h4);

        // Release: sequential 4, 8, 12.
        reset = 1'b0;
        step();
        check_output("seq_pc1",    pc_result,               32'h4);
        check_output("seq_valid1", {31'b0, pc_valid},       32'h1);
        step();
        check_output("seq_pc2",    pc_result,               32'h8);
        step();
        check_output("seq_pc3",    pc_result,               32'hC);
        check_output("seq_add3",   pc_add_result,           32'h10);

        // Jump to 0x100, then take a negative-offset branch.
        jump_en = 1'b1; jump_target = 32'h100;
        step();
        idle_inputs();
        check_output("jump_pc100", pc_result, 32'h100);
        branch_taken = 1'b1; branch_base = 32'h104; branch_offset = 32'hFFFF_FFFE;
        #1;
        check_output("branch_target_neg", branch_target, 32'h0FC);
        step();
        idle_inputs();
        check_output("branch_pc",       pc_result,                32'h0FC);
        check_output("branch_misalign", {31'b0, misalign_err},    32'h0);

        // Jump and branch together: the jump wins.
        jump_en = 1'b1; jump_target = 32'h400;
        branch_taken = 1'b1; branch_base = 32'h200; branch_offset = 32'h0;
        #1;
        check_output("both_branch_target", branch_target, 32'h200);
        step();
        idle_inputs();
        check_output("jump_beats_branch", pc_result, 32'h400);

        // Three-cycle stall: branch 0x80, then jump 0x90 overwrites it.
        stall = 1'b1; branch_taken = 1'b1; branch_base = 32'h80;
        step();
        check_output("stall1_pc",      pc_result,                 32'h400);
        check_output("stall1_pending", {31'b0, redirect_pending}, 32'h1);
        branch_taken = 1'b0; branch_base = 32'h0;
        jump_en = 1'b1; jump_target = 32'h90;
        step();
        check_output("stall2_pc",      pc_result,                 32'h400);
        jump_en = 1'b0; jump_target = 32'h0;
        step();
        check_output("stall3_pc",      pc_result,                 32'h400);
        check_output("stall3_pending", {31'b0, redirect_pending}, 32'h1);
        stall = 1'b0;
        step();
        check_output("release_pc",      pc_result,                 32'h90);
        check_output("release_pending", {31'b0, redirect_pending}, 32'h0);
        step();
        check_output("after_release_pc", pc_result, 32'h94);

        // A younger redirect on the release cycle beats the buffered one.
        stall = 1'b1; branch_taken = 1'b1; branch_base = 32'h80;
        step();
        idle_inputs();
        jump_en = 1'b1; jump_target = 32'h500;
        step();
        idle_inputs();
        check_output("younger_wins_pc",      pc_result,                 32'h500);
        check_output("younger_wins_pending", {31'b0, redirect_pending}, 32'h0);

        // Wrap-around at the top of the address space.
        jump_en = 1'b1; jump_target = 32'hFFFF_FFFC;
        step();
        idle_inputs();
        check_output("top_pc",  pc_result,     32'hFFFF_FFFC);
        check_output("top_add", pc_add_result, 32'h0);
        step();
        check_output("wrap_pc",       pc_result,             32'h0);
        check_output("wrap_misalign", {31'b0, misalign_err}, 32'h0);

        // Misaligned direct jump: aligned load, then a one-cycle pulse.
        jump_en = 1'b1; jump_target = 32'h203;
        step();
        idle_inputs();
        check_output("misjump_pc",       pc_result,             32'h200);
        check_output("misjump_err",      {31'b0, misalign_err}, 32'h1);
        step();
        check_output("misjump_err_drop", {31'b0, misalign_err}, 32'h0);
        check_output("misjump_next_pc",  pc_result,             32'h204);

        // Misaligned buffered jump: no pulse at buffering, pulse at load.
        stall = 1'b1; jump_en = 1'b1; jump_target = 32'h305;
        step();
        idle_inputs();
        check_output("misbuf_no_err", {31'b0, misalign_err}, 32'h0);
        step();
        check_output("misbuf_pc",  pc_result,             32'h304);
        check_output("misbuf_err", {31'b0, misalign_err}, 32'h1);

        // Reset mid-stall discards the pending redirect.
        stall = 1'b1; jump_en = 1'b1; jump_target = 32'h700;
        step();
        jump_en = 1'b0; jump_target = 32'h0;
        check_output("pre_reset_pending", {31'b0, redirect_pending}, 32'h1);
        reset = 1'b1;
        step();
        check_output("midreset_pc",      pc_result,                 32'h0);
        check_output("midreset_pending", {31'b0, redirect_pending}, 32'h0);
        check_output("midreset_valid",   {31'b0, pc_valid},         32'h0);
        reset = 1'b0; stall = 1'b0;
        step();
        check_output("postreset_pc",    pc_result,         32'h4);
        check_output("postreset_valid", {31'b0, pc_valid}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
